// File: rtl/float_to_int_converter.sv
// Single-stage converter from a 13-bit sign/exponent/fraction float to an
// 8-bit signed integer. Truncates toward zero; saturates or flushes with flags.
module float_to_int_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] float_i,
  output logic [7:0]  int_o,
  output logic        overflow,
  output logic        underflow
);

  logic        sign;
  logic [3:0]  exp_w;
  logic [7:0]  frac;
  logic [15:0] mag;

  logic [7:0]  int_d, int_q;
  logic        ovf_d, ovf_q;
  logic        unf_d, unf_q;

  assign sign  = float_i[12];
  assign exp_w = float_i[11:8];
  assign frac  = float_i[7:0];

  // 16-bit magnitude holds the largest left shift (255 << 7) without loss
  always_comb begin
    mag = '0;
    if (exp_w <= 4'd8) begin
      mag = {8'h00, frac} >> (4'd8 - exp_w);
    end else begin
      mag = {8'h00, frac} << (exp_w - 4'd8);
    end
  end

  always_comb begin
    int_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (frac != 8'h00) begin
      if (mag == 16'd0) begin
        unf_d = 1'b1;
      end else if (!sign && (mag > 16'd127)) begin
        int_d = 8'h7F;
        ovf_d = 1'b1;
      end else if (sign && (mag > 16'd128)) begin
        int_d = 8'h80;
        ovf_d = 1'b1;
      end else if (sign) begin
        // mag == 128 negates to 0x80, which is exactly -128
        int_d = 8'h00 - mag[7:0];
      end else begin
        int_d = mag[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      int_q <= int_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign int_o     = int_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_float_to_int_converter.sv
// Directed and exhaustive self-checking bench for float_to_int_converter.
module tb_float_to_int_converter;

  logic        clk;
  logic        rst;
  logic [12:0] float_i;
  logic [7:0]  int_o;
  logic        overflow;
  logic        underflow;

  int checks;
  int failures;

  float_to_int_converter dut (
    .clk      (clk),
    .rst      (rst),
    .float_i  (float_i),
    .int_o    (int_o),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply an operand, then sample one edge later (#1 after the edge)
  task automatic step(input logic [12:0] v);
    float_i = v;
    @(posedge clk);
    #1;
  endtask

  // Reference: value = f * 2^e / 256 using integer arithmetic
  function automatic void model(input logic [12:0] v, output logic [7:0] i,
                                output logic o, output logic u);
    int m;
    m = (int'(v[7:0]) * (1 << v[11:8])) / 256;
    i = 8'h00; o = 1'b0; u = 1'b0;
    if (v[7:0] == 8'h00) begin
      i = 8'h00;
    end else if (m == 0) begin
      u = 1'b1;
    end else if (!v[12] && m > 127) begin
      i = 8'h7F; o = 1'b1;
    end else if (v[12] && m > 128) begin
      i = 8'h80; o = 1'b1;
    end else begin
      i = v[12] ? 8'(-m) : 8'(m);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int unsigned k = 0; k < 2; k++) begin
      step(13'h1FFF);
      checks++;
      if ({int_o, overflow, underflow} !== {8'h00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_hold%0d got int=%h ovf=%b unf=%b want int=00 ovf=0 unf=0",
                 k, int_o, overflow, underflow);
      end
    end
    rst = 1'b0;
    step(13'h03A0);
    checks++;
    if ({int_o, overflow, underflow} !== {8'h05, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_release got int=%h ovf=%b unf=%b want int=05 ovf=0 unf=0",
               int_o, overflow, underflow);
    end
    // Reset wins over an overflowing operand on the same edge
    rst = 1'b1;
    step(13'h0880);
    checks++;
    if ({int_o, overflow, underflow} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_priority got int=%h ovf=%b unf=%b want int=00 ovf=0 unf=0",
               int_o, overflow, underflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [12:0] vin  [11] = '{13'h13A0, 13'h02E0, 13'h12E0, 13'h07FF, 13'h1880,
                               13'h0880, 13'h1FFF, 13'h0080, 13'h1001, 13'h1A00,
                               13'h03A0};
    logic [7:0]  vint [11] = '{8'hFB, 8'h03, 8'hFD, 8'h7F, 8'h80,
                               8'h7F, 8'h80, 8'h00, 8'h00, 8'h00,
                               8'h05};
    logic        vovf [11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic        vunf [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    for (int unsigned k = 0; k < 11; k++) begin
      step(vin[k]);
      checks++;
      if ({int_o, overflow, underflow} !== {vint[k], vovf[k], vunf[k]}) begin
        failures++;
        $display("FAIL directed in=%h got int=%h ovf=%b unf=%b want int=%h ovf=%b unf=%b",
                 vin[k], int_o, overflow, underflow, vint[k], vovf[k], vunf[k]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] ei;
    logic       eo, eu;
    for (int unsigned k = 0; k < 8192; k++) begin
      step(13'(k));
      model(13'(k), ei, eo, eu);
      checks++;
      if ({int_o, overflow, underflow} !== {ei, eo, eu}) begin
        failures++;
        $display("FAIL sweep in=%h got int=%h ovf=%b unf=%b want int=%h ovf=%b unf=%b",
                 13'(k), int_o, overflow, underflow, ei, eo, eu);
      end
      checks++;
      if ((overflow & underflow) !== 1'b0) begin
        failures++;
        $display("FAIL flags_exclusive in=%h got ovf=%b unf=%b want not both 1",
                 13'(k), overflow, underflow);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned k = 0; k < 6; k++) begin
      if (k[0] == 1'b0) begin
        step(13'h0880);
        checks++;
        if ({int_o, overflow, underflow} !== {8'h7F, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL b2b_ovf%0d got int=%h ovf=%b unf=%b want int=7f ovf=1 unf=0",
                   k, int_o, overflow, underflow);
        end
      end else begin
        step(13'h03A0);
        checks++;
        if ({int_o, overflow, underflow} !== {8'h05, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL b2b_five%0d got int=%h ovf=%b unf=%b want int=05 ovf=0 unf=0",
                   k, int_o, overflow, underflow);
        end
      end
    end
  endtask

  task automatic test_hold();
    step(13'h13A0);
    float_i = 13'h0880;
    #3;
    checks++;
    if ({int_o, overflow, underflow} !== {8'hFB, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL hold_between_edges got int=%h ovf=%b unf=%b want int=fb ovf=0 unf=0",
               int_o, overflow, underflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({int_o, overflow, underflow} !== {8'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL hold_next_edge got int=%h ovf=%b unf=%b want int=7f ovf=1 unf=0",
               int_o, overflow, underflow);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    float_i  = 13'h1FFF;
    test_reset();
    test_directed();
    test_exhaustive();
    test_back_to_back();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_to_int_converter.md
# float_to_int_converter

Converts a 13-bit custom floating-point number (sign, 4-bit exponent, 8-bit fraction) to an 8-bit two's-complement signed integer, truncating toward zero. Out-of-range results saturate, and sub-unity results flush to zero, each with a status flag. The block is a single-stage registered datapath in the number-format conversion path: one conversion is accepted every clock, and the result appears one cycle later.

## Interface
Parameters: none; all widths are fixed.

- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, synchronous and active-high
- float_i  input  13  floating-point operand: [12] sign s, [11:8] exponent e (unsigned 0..15), [7:0] fraction f
- int_o  output  8  signed two's-complement result (registered)
- overflow  output  1  result saturated because |value| was out of range (registered)
- underflow  output  1  nonzero input truncated to 0 (registered)

## Operation
- Encoding: value = (-1)^s × 0.f × 2^e = f × 2^(e−8).
  - f is a binary fraction with the point left of bit 7.
  - No hidden bit; f[7]=0 is legal and uses the same formula.
- Magnitude: mag = floor(f × 2^(e−8)).
  - For e ≤ 8: mag = f >> (8−e).
  - For e > 8: mag = f << (e−8).
  - Compute in at least 16 bits; the maximum is 255 × 128 = 32640, so nothing may be lost before range checks.
- Zero: f = 0 gives int_o = 0 and both flags 0, for any s and e. Negative zero also gives 0.
- Underflow: f ≠ 0 and mag = 0 (only possible for e ≤ 7) gives int_o = 0 and underflow = 1, for either sign.
- Overflow, positive (s = 0): mag > 127 gives int_o = 0x7F and overflow = 1.
- Overflow, negative (s = 1): mag > 128 gives int_o = 0x80 and overflow = 1.
  - mag = 128 with s = 1 is exactly −128: int_o = 0x80 with no flag.
- Normal: int_o = s ? −mag : mag (8-bit two's complement), both flags 0.
- Flags are mutually exclusive; at most one is set in any cycle.
- Rounding is always truncation toward zero, never round-to-nearest.

## Timing
- Conversion logic is combinational from float_i. int_o, overflow and underflow are registered on the rising clk edge.
- Latency: 1 cycle. Outputs after edge N reflect float_i sampled at edge N.
- Throughput: one conversion per cycle. There is no handshake or enable; a new operand is captured every edge.
- Reset: when rst = 1 at a rising edge, int_o = 0x00, overflow = 0, underflow = 0.
  - Reset has priority over the data captured on that edge.
  - The first result after reset is the operand sampled on the first edge with rst = 0.
- Outputs hold their value between edges; float_i changes between edges have no effect until the next edge.

## Test plan
- Reset: hold rst = 1 with float_i = 0x1FFF for 2 edges -> int_o = 0x00, overflow = 0, underflow = 0. Release and apply 0_0011_10100000 (+5.0) -> one edge later int_o = 0x05, flags 0.
- Sign and truncation:
  - 1_0011_10100000 -> int_o = 0xFB (−5).
  - 0_0010_11100000 (3.5) -> 0x03.
  - 1_0010_11100000 -> 0xFD (−3).
- Range limits:
  - 0_0111_11111111 (127.5) -> 0x7F, no flag.
  - 1_1000_10000000 (−128) -> 0x80, no flag.
  - 0_1000_10000000 (+128) -> 0x7F, overflow = 1.
  - 1_1111_11111111 -> 0x80, overflow = 1.
- Underflow and zero:
  - 0_0000_10000000 (0.5) -> 0x00, underflow = 1.
  - 1_0000_00000001 -> 0x00, underflow = 1.
  - 1_1010_00000000 -> 0x00, both flags 0.
- Exhaustive: sweep all 8192 float_i codes one per cycle and compare every output against a reference model of the rules above, checked one cycle later. Also confirm the flags are never both 1.
- Back-to-back changes: alternate +128-overflow and +5 operands on consecutive cycles -> outputs alternate 0x7F/overflow and 0x05/no flag with exactly 1-cycle latency.
